line_darkener: RTL and testbench
================================

# line_darkener

Write-back stage of the thread-placement loop. Once the line search has chosen a thread, this block walks that line's pixel addresses and commits the thread to the residual image. For each pixel it does a read-modify-write of image memory: subtract the per-thread darkness and saturate to the signed 9-bit residual range. It is the writer counterpart of the per-pixel reduction calculator, which scores pixels against the same memory and the same darkness constant.

## Interface
- ADDR_W, 16, pixel address width (256x256 image)
- DARKEN, 150, darkness subtracted per pixel per thread
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- pix_valid  in  1  pixel address offered
- pix_addr  in  ADDR_W  pixel address
- pix_last  in  1  marks the final pixel of the line
- pix_ready  out  1  block accepts pixels
- mem_rd_addr  out  ADDR_W  image read address; memory has 1-cycle registered read latency
- mem_rd_data  in  9  signed residual returned one cycle after the address
- mem_wr_en  out  1  image write strobe
- mem_wr_addr  out  ADDR_W  write address
- mem_wr_data  out  9  signed value to write
- done  out  1  one-cycle pulse after the line's last write
- pix_count  out  16  number of pixels written for the current or most recent line

## Operation
- An accept occurs when pix_valid and pix_ready are both high on a clock edge.
- mem_rd_addr = pix_addr combinationally, whether or not an accept occurs.
- FSM states:
  - IDLE: pix_ready=1. An accept moves to RUN, or to DRAIN if pix_last=1. The first accept clears pix_count.
  - RUN: pix_ready=1. An accept with pix_last=1 moves to DRAIN.
  - DRAIN: pix_ready=0. Waits until the pipeline is empty, then moves to DONE.
  - DONE: done=1 and pix_ready=0 for one cycle, then returns to IDLE.
- Pipeline stages:
  - S0: accept. The address is captured into s1_addr with s1_vld.
  - S1: old value = mem_rd_data, overridden by forwarding. Compute a 10-bit signed difference, old − DARKEN. Clamp to −256 if below −256. Register the result into the write regs.
  - S2: write regs drive mem_wr_en/addr/data. The memory commits at the end of that cycle. The write is then copied into the history reg (hist_vld, hist_addr, hist_data).
- Forwarding, most recent first:
  - If the write regs are valid with addr == s1_addr, use mem_wr_data.
  - Else if the history reg is valid with addr == s1_addr, use hist_data.
  - Else use mem_rd_data.
  - This covers same-address pixels at distance 1 and 2. Memory read-during-write returns old data.
- pix_count increments on every mem_wr_en cycle and holds after done until the next line's first accept.
- The upper bound on the result is never reached, since subtraction only lowers the value. No positive clamp is needed.

## Timing
- Reset values: pix_ready=0 during reset and 1 from the first cycle after reset. mem_wr_en=0, mem_wr_addr=0, mem_wr_data=0, done=0, pix_count=0. FSM is in IDLE. All stage and history valids are 0.
- Pixel accepted in cycle T: its write is visible (mem_wr_en=1) in T+2.
- Throughput is one pixel per cycle while pix_valid is held in RUN.
- Last pixel accepted in T: write in T+2, done pulses in T+3, pix_ready returns high in T+4.
- Reset asserted mid-line:
  - Any in-flight pixel is discarded.
  - No write occurs in the cycle after reset.
  - done is not pulsed.
  - pix_count returns to 0.
- pix_valid held high during DRAIN/DONE is not accepted. That pixel is accepted on the first IDLE cycle.
- An address arriving while pix_ready=0 is ignored, even though mem_rd_addr follows it.

## Test plan
- Single pixel: mem[0x0010]=100; accept 0x0010 with last=1 at T → T+2 write addr 0x0010, data −50; done pulse at T+3; pix_count=1.
- Saturation: mem[A]=−200, mem[B]=−106, mem[C]=−105, streamed as one line → writes −256, −256, −255; pix_count=3.
- Back-to-back same address: mem[A]=255, pixels A,A,A (last on third) → writes 105, −45, −195 on consecutive cycles; mem[A]=−195 afterwards.
- Distance-2 hazard: mem[A]=200, mem[B]=0, pixels A,B,A → writes A=50, B=−150, A=−100.
- Drain/backpressure: line of 4 pixels, with pix_valid held high carrying the next line's first address → pix_ready low from the cycle after the last accept through done; the new pixel is accepted in IDLE; pix_count goes 4 → 0 → 1.
- Reset mid-line: accept 2 pixels, assert reset for one cycle at T+1 → no mem_wr_en afterwards, no done pulse, pix_count=0, memory for those addresses unchanged.

Source files
------------

// File: rtl/line_darkener.sv
// Thread write-back: walks a line's pixel addresses and commits the thread darkness
// to the residual image through a read-modify-write pipeline with store forwarding.
module line_darkener #(
    parameter int ADDR_W = 16,
    parameter int DARKEN = 150
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pix_valid,
    input  logic [ADDR_W-1:0] pix_addr,
    input  logic              pix_last,
    output logic              pix_ready,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic signed [8:0] mem_rd_data,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic signed [8:0] mem_wr_data,
    output logic              done,
    output logic [15:0]       pix_count
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic signed [9:0] DARKEN_W = 10'(DARKEN);

    state_t              state_reg, state_next;
    logic                accept;
    logic                clear_count;

    logic                s1_vld_reg;
    logic [ADDR_W-1:0]   s1_addr_reg;
    logic                wr_vld_reg;
    logic [ADDR_W-1:0]   wr_addr_reg;
    logic signed [8:0]   wr_data_reg;
    logic                hist_vld_reg;
    logic [ADDR_W-1:0]   hist_addr_reg;
    logic signed [8:0]   hist_data_reg;
    logic [15:0]         count_reg;

    logic signed [8:0]   old_value;
    logic signed [9:0]   diff;
    logic signed [8:0]   new_value;

    assign pix_ready   = !reset && (state_reg == IDLE || state_reg == RUN);
    assign accept      = pix_valid && pix_ready;
    assign done        = !reset && (state_reg == DONE);
    assign mem_rd_addr = pix_addr;
    // Gating with reset drops a write that would land in the reset cycle itself.
    assign mem_wr_en   = wr_vld_reg && !reset;
    assign mem_wr_addr = wr_addr_reg;
    assign mem_wr_data = wr_data_reg;
    assign pix_count   = count_reg;

    always_comb begin
        state_next  = state_reg;
        clear_count = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    clear_count = 1'b1;
                    state_next  = pix_last ? DRAIN : RUN;
                end
            end
            RUN: begin
                if (accept && pix_last) begin
                    state_next = DRAIN;
                end
            end
            // With S1 empty, the only remaining pixel is in the write regs this cycle.
            DRAIN: begin
                if (!s1_vld_reg) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Memory returns pre-write data, so the two most recent writes must be forwarded.
    always_comb begin
        if (wr_vld_reg && (wr_addr_reg == s1_addr_reg)) begin
            old_value = wr_data_reg;
        end else if (hist_vld_reg && (hist_addr_reg == s1_addr_reg)) begin
            old_value = hist_data_reg;
        end else begin
            old_value = mem_rd_data;
        end
        diff = {old_value[8], old_value} - DARKEN_W;
        if (diff[9] && !diff[8]) begin
            new_value = 9'sh100;
        end else begin
            new_value = diff[8:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            s1_vld_reg    <= 1'b0;
            s1_addr_reg   <= '0;
            wr_vld_reg    <= 1'b0;
            wr_addr_reg   <= '0;
            wr_data_reg   <= '0;
            hist_vld_reg  <= 1'b0;
            hist_addr_reg <= '0;
            hist_data_reg <= '0;
            count_reg     <= '0;
        end else begin
            state_reg  <= state_next;
            s1_vld_reg <= accept;
            if (accept) begin
                s1_addr_reg <= pix_addr;
            end
            wr_vld_reg <= s1_vld_reg;
            if (s1_vld_reg) begin
                wr_addr_reg <= s1_addr_reg;
                wr_data_reg <= new_value;
            end
            hist_vld_reg <= wr_vld_reg;
            if (wr_vld_reg) begin
                hist_addr_reg <= wr_addr_reg;
                hist_data_reg <= wr_data_reg;
            end
            if (clear_count) begin
                count_reg <= '0;
            end else if (wr_vld_reg) begin
                count_reg <= count_reg + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_line_darkener.sv
// Bench for line_darkener: directed vector table, drain/reset sequences and a random
// stream checked against a saturating-subtract reference image.
module tb_line_darkener;

    localparam int ADDR_W = 16;
    localparam int DARKEN = 150;

    logic              clk = 1'b0;
    logic              reset;
    logic              pix_valid;
    logic [ADDR_W-1:0] pix_addr;
    logic              pix_last;
    logic              pix_ready;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic signed [8:0] mem_rd_data;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic signed [8:0] mem_wr_data;
    logic              done;
    logic [15:0]       pix_count;

    always #5 clk = ~clk;

    line_darkener #(.ADDR_W(ADDR_W), .DARKEN(DARKEN)) dut (
        .clk         (clk),
        .reset       (reset),
        .pix_valid   (pix_valid),
        .pix_addr    (pix_addr),
        .pix_last    (pix_last),
        .pix_ready   (pix_ready),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_data (mem_wr_data),
        .done        (done),
        .pix_count   (pix_count)
    );

    // Image memory: registered read, read-during-write returns old data.
    logic signed [8:0] mem [0:65535];
    logic              poke_en;
    logic [15:0]       poke_addr;
    logic signed [8:0] poke_data;

    always @(posedge clk) begin
        mem_rd_data <= mem[mem_rd_addr];
        if (poke_en) mem[poke_addr] <= poke_data;
        else if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
    end

    typedef struct {
        logic [15:0] addr;
        int          data;
        int          old;
        int          cyc;
    } wr_t;

    typedef struct {
        logic [15:0] addr;
        logic        last;
        logic        do_init;
        int          init;
        int          exp;
    } vec_t;

    vec_t tbl [10];
    wr_t  exp_q [$];
    int   ref_mem [0:65535];

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   cyc_s = 0;
    int   count_s = 0;
    int   exp_done = -1;
    int   exp_count = 0;
    int   last_acc = -100;
    int   line_cnt = 0;
    int   tbl_exp = 0;
    bit   use_tbl = 0;
    bit   accepted = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: sample and check outputs, update the model on accept, then advance.
    task automatic tick();
        wr_t e;
        int  nv;
        bit  exp_r;
        #2;
        cyc_s    = cyc;
        count_s  = int'(pix_count);
        accepted = pix_valid && pix_ready;
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL write_missing: addr=%h data=%0d due cycle %0d, not written by cycle %0d",
                     e.addr, e.data, e.cyc, cyc);
        end
        if (mem_wr_en) begin
            $display("wr cyc=%0d addr=%h data=%0d", cyc, mem_wr_addr, mem_wr_data);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_write: addr=%h data=%0d, required no write (cycle %0d)",
                         mem_wr_addr, mem_wr_data, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", int'(mem_wr_addr), int'(e.addr));
                chk("wr_data", int'(mem_wr_data), e.data);
                chk("wr_cycle", cyc, e.cyc);
            end
        end
        if (done || cyc == exp_done) begin
            chk("done_pulse", int'(done), int'(cyc == exp_done));
            if (cyc == exp_done) chk("count_at_done", count_s, exp_count);
        end
        if (reset) begin
            chk("ready_in_reset", int'(pix_ready), 0);
        end else begin
            exp_r = !(cyc > last_acc && cyc < last_acc + 4);
            chk("pix_ready", int'(pix_ready), int'(exp_r));
        end
        chk("rd_addr", int'(mem_rd_addr), int'(pix_addr));
        if (accepted) begin
            nv = ref_mem[pix_addr] - DARKEN;
            if (nv < -256) nv = -256;
            e.addr = pix_addr;
            e.old  = ref_mem[pix_addr];
            e.data = use_tbl ? tbl_exp : nv;
            e.cyc  = cyc + 2;
            exp_q.push_back(e);
            ref_mem[pix_addr] = nv;
            line_cnt++;
            if (pix_last) begin
                last_acc  = cyc;
                exp_done  = cyc + 3;
                exp_count = line_cnt;
                line_cnt  = 0;
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic poke(input logic [15:0] a, input int v);
        poke_en   = 1'b1;
        poke_addr = a;
        poke_data = 9'(v);
        ref_mem[a] = v;
        tick();
        poke_en = 1'b0;
    endtask

    task automatic run_line(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            pix_valid = 1'b1;
            pix_addr  = tbl[i].addr;
            pix_last  = tbl[i].last;
            use_tbl   = 1'b1;
            tbl_exp   = tbl[i].exp;
            tick();
            chk("tbl_accept", int'(accepted), 1);
        end
        pix_valid = 1'b0;
        pix_last  = 1'b0;
        use_tbl   = 1'b0;
        repeat (6) tick();
    endtask

    initial begin
        int start;
        int lcyc;
        int waited;
        logic [15:0] raddr [6];

        tbl[0] = '{16'h0010, 1'b1, 1'b1,  100,  -50};
        tbl[1] = '{16'h0100, 1'b0, 1'b1, -200, -256};
        tbl[2] = '{16'h0101, 1'b0, 1'b1, -106, -256};
        tbl[3] = '{16'h0102, 1'b1, 1'b1, -105, -255};
        tbl[4] = '{16'h0200, 1'b0, 1'b1,  255,  105};
        tbl[5] = '{16'h0200, 1'b0, 1'b0,    0,  -45};
        tbl[6] = '{16'h0200, 1'b1, 1'b0,    0, -195};
        tbl[7] = '{16'h0300, 1'b0, 1'b1,  200,   50};
        tbl[8] = '{16'h0301, 1'b0, 1'b1,    0, -150};
        tbl[9] = '{16'h0300, 1'b1, 1'b0,    0, -100};

        reset     = 1'b1;
        pix_valid = 1'b0;
        pix_addr  = '0;
        pix_last  = 1'b0;
        poke_en   = 1'b0;
        poke_addr = '0;
        poke_data = '0;
        @(posedge clk);
        #1;
        repeat (3) tick();
        reset = 1'b0;
        #1;
        chk("rst_ready", int'(pix_ready), 1);
        chk("rst_wr_en", int'(mem_wr_en), 0);
        chk("rst_wr_addr", int'(mem_wr_addr), 0);
        chk("rst_wr_data", int'(mem_wr_data), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_count", int'(pix_count), 0);

        // Directed vector table, one line per run of entries ending in last.
        for (int i = 0; i < 10; i++) begin
            if (tbl[i].do_init) poke(tbl[i].addr, tbl[i].init);
        end
        start = 0;
        for (int i = 0; i < 10; i++) begin
            if (tbl[i].last) begin
                run_line(start, i);
                start = i + 1;
            end
        end
        chk("mem_after_same_addr", int'(mem[16'h0200]), -195);

        // Drain/backpressure: next line's first pixel held valid through DRAIN and DONE.
        for (int k = 0; k < 4; k++) poke(16'h0400 + 16'(k), 10 * (k + 1));
        poke(16'h0500, 0);
        for (int k = 0; k < 4; k++) begin
            pix_valid = 1'b1;
            pix_addr  = 16'h0400 + 16'(k);
            pix_last  = (k == 3);
            tick();
        end
        lcyc     = last_acc;
        pix_addr = 16'h0500;
        pix_last = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (cyc_s == lcyc + 4) begin
                chk("drain_accept_in_idle", int'(accepted), 1);
                pix_valid = 1'b0;
                pix_last  = 1'b0;
            end else if (cyc_s < lcyc + 4) begin
                chk("drain_no_accept", int'(accepted), 0);
            end
            if (cyc_s == lcyc + 3) chk("drain_count_4", count_s, 4);
            if (cyc_s == lcyc + 5) chk("drain_count_0", count_s, 0);
            if (cyc_s == lcyc + 7) chk("drain_count_1", count_s, 1);
        end

        // Reset mid-line: two accepted pixels are discarded before their writes.
        poke(16'h0600, 40);
        poke(16'h0601, -100);
        pix_valid = 1'b1;
        pix_addr  = 16'h0600;
        pix_last  = 1'b0;
        tick();
        pix_addr = 16'h0601;
        tick();
        pix_valid = 1'b0;
        reset     = 1'b1;
        for (int i = exp_q.size() - 1; i >= 0; i--) ref_mem[exp_q[i].addr] = exp_q[i].old;
        exp_q.delete();
        line_cnt = 0;
        exp_done = -1;
        tick();
        reset = 1'b0;
        #1;
        chk("reset_count", int'(pix_count), 0);
        repeat (6) tick();
        chk("reset_mem_a", int'(mem[16'h0600]), 40);
        chk("reset_mem_b", int'(mem[16'h0601]), -100);

        // Random stream over a few addresses to exercise forwarding hazards.
        for (int k = 0; k < 6; k++) begin
            raddr[k] = 16'h0700 + 16'(k);
            poke(raddr[k], int'($urandom_range(511)) - 256);
        end
        for (int n = 0; n < 400; n++) begin
            pix_valid = ($urandom_range(3) != 0);
            pix_addr  = raddr[$urandom_range(5)];
            pix_last  = ($urandom_range(7) == 0);
            tick();
        end
        if (line_cnt > 0) begin
            pix_valid = 1'b1;
            pix_last  = 1'b1;
            waited    = 0;
            while (line_cnt > 0 && waited < 10) begin
                tick();
                waited++;
            end
            chk("close_line_accepted", line_cnt, 0);
        end
        pix_valid = 1'b0;
        pix_last  = 1'b0;
        repeat (8) tick();
        chk("queue_drained", exp_q.size(), 0);
        for (int k = 0; k < 6; k++) chk("rand_mem", int'(mem[raddr[k]]), ref_mem[raddr[k]]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
